// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with PC register and IF/ID pipeline register.
//
// Parameters
//   N         PC / branch-target width in bits
//   PC_RESET  PC value loaded on reset
//
// Ports
//   clk            in   clock, all state updates on rising edge
//   reset          in   synchronous active-high reset
//   stall          in   hold PC and IF/ID (hazard unit request)
//   flush          in   load a bubble into IF/ID
//   pc_src         in   redirect PC to branch_target
//   branch_target  in   N   redirect address (low two bits ignored)
//   imem_addr      out  N   instruction memory address (current PC)
//   imem_data      in   32  instruction word for imem_addr
//   if_id_pc       out  N   PC of the instruction held in IF/ID
//   if_id_instr    out  32  instruction held in IF/ID
//   if_id_valid    out  1   IF/ID holds a real instruction
//   fetch_count    out  32  instructions latched into IF/ID since reset
module fetch_stage #(
  parameter int unsigned     N        = 64,
  parameter logic [N-1:0]    PC_RESET = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          pc_src,
  input  logic [N-1:0]  branch_target,
  output logic [N-1:0]  imem_addr,
  input  logic [31:0]   imem_data,
  output logic [N-1:0]  if_id_pc,
  output logic [31:0]   if_id_instr,
  output logic          if_id_valid,
  output logic [31:0]   fetch_count
);

  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] if_id_pc_q, if_id_pc_d;
  logic [31:0]  if_id_instr_q, if_id_instr_d;
  logic         if_id_valid_q, if_id_valid_d;
  logic [31:0]  fetch_count_q, fetch_count_d;

  // PC: redirect wins over stall; flush has no effect on the PC.
  always_comb begin
    pc_d = pc_q;
    if (pc_src) begin
      pc_d = {branch_target[N-1:2], 2'b00};
    end else if (!stall) begin
      pc_d = pc_q + N'(4);
    end
  end

  // IF/ID: flush wins over stall; the counter only counts real latches.
  always_comb begin
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;
    if (flush) begin
      if_id_pc_d    = '0;
      if_id_instr_d = '0;
      if_id_valid_d = 1'b0;
    end else if (!stall) begin
      if_id_pc_d    = pc_q;
      if_id_instr_d = imem_data;
      if_id_valid_d = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= PC_RESET;
      if_id_pc_q    <= '0;
      if_id_instr_q <= '0;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage (N=64, PC_RESET=0).
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        pc_src = 1'b0;
  logic [63:0] branch_target = '0;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.N(64), .PC_RESET(64'h0)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word encodes the low address byte.
  assign imem_data = 32'h8B00_0000 + {24'h0, imem_addr[7:0]};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check every observable output against hand-computed values.
  task automatic chk_all(input string tag, input logic [63:0] addr, input logic [63:0] pc,
                         input logic [31:0] instr, input logic valid, input logic [31:0] cnt);
    chk({tag, ".imem_addr"}, imem_addr, addr);
    chk({tag, ".if_id_pc"}, if_id_pc, pc);
    chk({tag, ".if_id_instr"}, {32'h0, if_id_instr}, {32'h0, instr});
    chk({tag, ".if_id_valid"}, {63'h0, if_id_valid}, {63'h0, valid});
    chk({tag, ".fetch_count"}, {32'h0, fetch_count}, {32'h0, cnt});
  endtask

  initial begin
    // Reset held for 5 edges.
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("rst", 64'h0, 64'h0, 32'h0, 1'b0, 32'd0);
    end

    // Free run: imem_addr 0,4,8,12,16 with IF/ID one cycle behind.
    reset = 1'b0;
    step(); chk_all("run1", 64'h4,  64'h0, 32'h8B00_0000, 1'b1, 32'd1);
    step(); chk_all("run2", 64'h8,  64'h4, 32'h8B00_0004, 1'b1, 32'd2);
    step(); chk_all("run3", 64'hC,  64'h8, 32'h8B00_0008, 1'b1, 32'd3);
    step(); chk_all("run4", 64'h10, 64'hC, 32'h8B00_000C, 1'b1, 32'd4);

    // Stall 3 cycles: everything frozen.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("stall", 64'h10, 64'hC, 32'h8B00_000C, 1'b1, 32'd4);
    end
    stall = 1'b0;

    // Mid-operation reset discards IF/ID.
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("rst2", 64'h0, 64'h0, 32'h0, 1'b0, 32'd0);
    end
    reset = 1'b0;
    step(); chk_all("re1", 64'h4, 64'h0, 32'h8B00_0000, 1'b1, 32'd1);
    step(); chk_all("re2", 64'h8, 64'h4, 32'h8B00_0004, 1'b1, 32'd2);

    // Branch at PC=8 to 0x103 (aligned to 0x100).
    pc_src = 1'b1; branch_target = 64'h103;
    step(); chk_all("br1", 64'h100, 64'h8, 32'h8B00_0008, 1'b1, 32'd3);
    pc_src = 1'b0;
    step(); chk_all("br2", 64'h104, 64'h100, 32'h8B00_0000, 1'b1, 32'd4);

    // Flush with stall: bubble, PC held, count unchanged.
    flush = 1'b1; stall = 1'b1;
    step(); chk_all("flst", 64'h104, 64'h0, 32'h0, 1'b0, 32'd4);
    // Flush alone: PC advances, bubble.
    stall = 1'b0;
    step(); chk_all("fl", 64'h108, 64'h0, 32'h0, 1'b0, 32'd4);
    flush = 1'b0;
    step(); chk_all("post_fl", 64'h10C, 64'h108, 32'h8B00_0008, 1'b1, 32'd5);

    // Redirect during stall to the top of the address space, then wrap.
    pc_src = 1'b1; stall = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFB;
    step(); chk_all("hi_br", 64'hFFFF_FFFF_FFFF_FFF8, 64'h108, 32'h8B00_0008, 1'b1, 32'd5);
    pc_src = 1'b0; stall = 1'b0;
    step(); chk_all("wrap1", 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF8, 32'h8B00_00F8, 1'b1, 32'd6);
    step(); chk_all("wrap2", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h8B00_00FC, 1'b1, 32'd7);
    step(); chk_all("wrap3", 64'h4, 64'h0, 32'h8B00_0000, 1'b1, 32'd8);

    // Reset overrides stall, flush and pc_src.
    reset = 1'b1; stall = 1'b1; flush = 1'b1; pc_src = 1'b1; branch_target = 64'h200;
    step(); chk_all("rst_ovr", 64'h0, 64'h0, 32'h0, 1'b0, 32'd0);
    reset = 1'b0; stall = 1'b0; flush = 1'b0; pc_src = 1'b0;
    step(); chk_all("rst_rel", 64'h4, 64'h0, 32'h8B00_0000, 1'b1, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
